// File: rtl/rsi_pkg.sv
// Shared constants, FSM state type and sizing helper for the multi-channel RSI engine.
package rsi_pkg;
  localparam int RSI_W     = 7;
  localparam int DIV_ITERS = 7;
  localparam int RSI_FLAT  = 50;

  typedef enum logic [1:0] {IDLE, UPDATE, DIVIDE, OUTPUT} state_t;

  function automatic int sum_width(input int price_w, input int n);
    return price_w + $clog2(n + 1);
  endfunction
endpackage

// File: rtl/rsi_div.sv
// Restoring divider, one quotient bit per cycle MSB first; the first bit is resolved on the start edge.
module rsi_div import rsi_pkg::*; #(
  parameter int DEN_W = 19,
  parameter int NUM_W = DEN_W + DIV_ITERS - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [RSI_W-1:0] quotient
);
  localparam int STEP_W = $clog2(DIV_ITERS + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(DIV_ITERS - 1);

  logic [NUM_W-1:0]  rem, dsr, src_rem, src_dsr, nxt_rem;
  logic [STEP_W-1:0] step;
  logic              busy, fits;

  // Quotient never exceeds 100, so the divisor starts shifted by DIV_ITERS-1.
  always_comb begin
    src_rem = start ? num : rem;
    src_dsr = start ? {den, (DIV_ITERS-1)'(0)} : dsr;
    fits    = (src_rem >= src_dsr);
    nxt_rem = fits ? src_rem - src_dsr : src_rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      dsr      <= '0;
      quotient <= '0;
      step     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start || busy) begin
        rem      <= nxt_rem;
        dsr      <= src_dsr >> 1;
        quotient <= {start ? {(RSI_W-1){1'b0}} : quotient[RSI_W-2:0], fits};
        step     <= start ? STEP_W'(1) : step + STEP_W'(1);
        busy     <= start ? 1'b1 : (step != STEP_LAST);
        done     <= !start && (step == STEP_LAST);
      end
    end
  end
endmodule

// File: rtl/rsi_multi_engine.sv
// Multi-channel RSI engine: per-stock delta windows sharing one update path and one divider.
module rsi_multi_engine import rsi_pkg::*; #(
  parameter int NUM_STOCKS = 4,
  parameter int ID_W       = 2,
  parameter int PRICE_W    = 14,
  parameter int N          = 10,
  parameter int RSI_OB     = 70,
  parameter int RSI_OS     = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ID_W+PRICE_W-1:0] in_data,
  input  logic                    clr_valid,
  input  logic [ID_W-1:0]         clr_id,
  output logic                    out_valid,
  output logic [ID_W-1:0]         out_id,
  output logic                    rsi_valid,
  output logic [RSI_W-1:0]        rsi,
  output logic                    buy_signal,
  output logic                    sell_signal
);
  localparam int SUM_W = sum_width(PRICE_W, N);
  localparam int CNT_W = $clog2(N + 1);
  localparam int PTR_W = $clog2(N);
  localparam int D_W   = PRICE_W + 1;
  localparam int DEN_W = SUM_W + 1;
  localparam int NUM_W = DEN_W + DIV_ITERS - 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N - 1);
  localparam logic [RSI_W-1:0] OB_Q     = RSI_W'(RSI_OB);
  localparam logic [RSI_W-1:0] OS_Q     = RSI_W'(RSI_OS);
  localparam logic [RSI_W-1:0] FLAT_Q   = RSI_W'(RSI_FLAT);

  logic [NUM_STOCKS-1:0]                  seen;
  logic [NUM_STOCKS-1:0][PRICE_W-1:0]     prev;
  logic [NUM_STOCKS-1:0][CNT_W-1:0]       cnt;
  logic [NUM_STOCKS-1:0][PTR_W-1:0]       wptr;
  logic [NUM_STOCKS-1:0][SUM_W-1:0]       gsum, lsum;
  logic [NUM_STOCKS-1:0][N-1:0][D_W-1:0]  ring;

  state_t             state;
  logic [ID_W-1:0]    lid;
  logic [PRICE_W-1:0] lprice;

  logic [D_W-1:0]   d, d_abs, old, old_abs;
  logic [SUM_W-1:0] g_nx, l_nx;
  logic [CNT_W-1:0] c_nx;
  logic [DEN_W-1:0] tot_nx;
  logic             full_nx, div_start, div_done;
  logic [NUM_W-1:0] div_num;
  logic [RSI_W-1:0] div_q;

  assign in_ready = (state == IDLE) && !clr_valid;

  // Deltas are kept as D_W-bit two's complement; the sign bit picks gain or loss.
  always_comb begin
    d       = D_W'(lprice) - D_W'(prev[lid]);
    d_abs   = d[D_W-1] ? -d : d;
    old     = ring[lid][wptr[lid]];
    old_abs = old[D_W-1] ? -old : old;
    g_nx    = gsum[lid];
    l_nx    = lsum[lid];
    c_nx    = cnt[lid];
    if (seen[lid]) begin
      if (cnt[lid] == CNT_FULL) begin
        if (old[D_W-1]) l_nx = l_nx - SUM_W'(old_abs);
        else            g_nx = g_nx - SUM_W'(old_abs);
      end else begin
        c_nx = cnt[lid] + CNT_W'(1);
      end
      if (d[D_W-1]) l_nx = l_nx + SUM_W'(d_abs);
      else          g_nx = g_nx + SUM_W'(d_abs);
    end
    full_nx = (c_nx == CNT_FULL);
    tot_nx  = {1'b0, g_nx} + {1'b0, l_nx};
  end

  assign div_start = (state == UPDATE) && full_nx && (tot_nx != '0);
  assign div_num   = NUM_W'(g_nx) * NUM_W'(100);

  rsi_div #(.DEN_W(DEN_W), .NUM_W(NUM_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .num      (div_num),
    .den      (tot_nx),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lid         <= '0;
      lprice      <= '0;
      seen        <= '0;
      prev        <= '0;
      cnt         <= '0;
      wptr        <= '0;
      gsum        <= '0;
      lsum        <= '0;
      ring        <= '0;
      out_valid   <= 1'b0;
      out_id      <= '0;
      rsi_valid   <= 1'b0;
      rsi         <= '0;
      buy_signal  <= 1'b0;
      sell_signal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_valid) begin
            seen[clr_id] <= 1'b0;
            cnt[clr_id]  <= '0;
            wptr[clr_id] <= '0;
            gsum[clr_id] <= '0;
            lsum[clr_id] <= '0;
          end else if (in_valid) begin
            lid    <= in_data[ID_W+PRICE_W-1:PRICE_W];
            lprice <= in_data[PRICE_W-1:0];
            state  <= UPDATE;
          end
        end
        UPDATE: begin
          seen[lid] <= 1'b1;
          prev[lid] <= lprice;
          gsum[lid] <= g_nx;
          lsum[lid] <= l_nx;
          cnt[lid]  <= c_nx;
          if (seen[lid]) begin
            ring[lid][wptr[lid]] <= d;
            wptr[lid] <= (wptr[lid] == PTR_LAST) ? '0 : wptr[lid] + PTR_W'(1);
          end
          if (div_start) begin
            state <= DIVIDE;
          end else begin
            // Warm-up or a perfectly flat window: no division needed.
            state       <= OUTPUT;
            out_valid   <= 1'b1;
            out_id      <= lid;
            rsi_valid   <= full_nx;
            rsi         <= full_nx ? FLAT_Q : '0;
            buy_signal  <= full_nx && (FLAT_Q < OS_Q);
            sell_signal <= full_nx && (FLAT_Q > OB_Q);
          end
        end
        DIVIDE: begin
          if (div_done) begin
            state       <= OUTPUT;
            out_valid   <= 1'b1;
            out_id      <= lid;
            rsi_valid   <= 1'b1;
            rsi         <= div_q;
            buy_signal  <= (div_q < OS_Q);
            sell_signal <= (div_q > OB_Q);
          end
        end
        OUTPUT: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
